// File: rtl/dig_core_pkg.sv
// Shared digital-core constants and types: sample format, per-filter buffer
// geometry and the replay sequencer state encoding.
package dig_core_pkg;

  localparam int unsigned SMPL_W    = 16;
  localparam int unsigned N_CH      = 2;

  typedef logic signed [SMPL_W-1:0] smpl_t;

  localparam int unsigned LP_DEPTH  = 1024;
  localparam int unsigned LP_WINDOW = 1021;
  localparam int unsigned HP_DEPTH  = 1536;
  localparam int unsigned HP_WINDOW = 1533;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } seq_state_e;

  // Counter/pointer width that stays at least one bit for degenerate sizes
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smpl_window_ram.sv
// Single-channel sample store: one write port, one read port with a
// registered read (1-cycle latency) that holds its value when not reading.
module smpl_window_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Storage array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/smpl_window_buf.sv
// Multi-channel circular sample buffer: stores one sample per channel per
// write strobe and replays the last WINDOW samples, oldest first, with tap index.
module smpl_window_buf
  import dig_core_pkg::*;
#(
  parameter int unsigned WIDTH    = SMPL_W,
  parameter int unsigned CHANNELS = N_CH,
  parameter int unsigned DEPTH    = LP_DEPTH,
  parameter int unsigned WINDOW   = LP_WINDOW,
  localparam int unsigned TW      = cnt_w(WINDOW)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrt_smpl,
  input  logic [CHANNELS*WIDTH-1:0] new_smpl,
  output logic [CHANNELS*WIDTH-1:0] smpl_out,
  output logic                      seq,
  output logic [TW-1:0]             tap_idx,
  output logic                      seq_done,
  output logic                      ovr
);

  localparam int unsigned AW = cnt_w(DEPTH);
  localparam int unsigned FW = $clog2(WINDOW + 1);

  localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] WIN_A      = AW'(WINDOW);
  localparam logic [AW-1:0] WRAP_A     = AW'(DEPTH - WINDOW);
  localparam logic [TW-1:0] TAP_LAST   = TW'(WINDOW - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(WINDOW);
  localparam logic [FW-1:0] FILL_PRIME = FW'(WINDOW - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [TW-1:0] tap_cnt_q, tap_cnt_d;
  logic          pending_q, pending_d;
  logic          ovr_q, ovr_d;
  logic          bubble_q, bubble_d;
  logic          seq_q, seq_d;
  logic [TW-1:0] tap_idx_q, tap_idx_d;
  logic          seq_done_q, seq_done_d;

  logic          rd_en_c;
  logic [AW-1:0] rd_addr_c;
  logic [AW-1:0] start_addr_c;
  logic [TW-1:0] cur_tap_c;

  // Wrap by compare so non-power-of-2 depths work
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // Oldest sample of the window ending just before wr_ptr
  assign start_addr_c = (wr_ptr_q >= WIN_A) ? (wr_ptr_q - WIN_A) : (wr_ptr_q + WRAP_A);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    tap_cnt_d  = tap_cnt_q;
    pending_d  = pending_q;
    ovr_d      = ovr_q;
    bubble_d   = bubble_q;
    seq_d      = 1'b0;
    tap_idx_d  = '0;
    seq_done_d = 1'b0;
    rd_en_c    = 1'b0;
    rd_addr_c  = rd_ptr_q;
    cur_tap_c  = tap_cnt_q;

    if (wrt_smpl) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end
      if (state_q != ST_IDLE) begin
        if (pending_q) begin
          ovr_d = 1'b1;
        end
        pending_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (wrt_smpl && (fill_q >= FILL_PRIME)) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // A relaunch spends one cycle here first to leave a gap between sequences
        if (bubble_q) begin
          bubble_d = 1'b0;
        end else begin
          rd_en_c   = 1'b1;
          rd_addr_c = start_addr_c;
          cur_tap_c = '0;
        end
      end
      ST_RUN: begin
        rd_en_c = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_en_c) begin
      seq_d     = 1'b1;
      tap_idx_d = cur_tap_c;
      rd_ptr_d  = ptr_inc(rd_addr_c);
      tap_cnt_d = cur_tap_c + TW'(1);
      state_d   = ST_RUN;
      if (cur_tap_c == TAP_LAST) begin
        seq_done_d = 1'b1;
        if (pending_q || wrt_smpl) begin
          state_d   = ST_LAUNCH;
          bubble_d  = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      tap_cnt_q  <= '0;
      pending_q  <= 1'b0;
      ovr_q      <= 1'b0;
      bubble_q   <= 1'b0;
      seq_q      <= 1'b0;
      tap_idx_q  <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      tap_cnt_q  <= tap_cnt_d;
      pending_q  <= pending_d;
      ovr_q      <= ovr_d;
      bubble_q   <= bubble_d;
      seq_q      <= seq_d;
      tap_idx_q  <= tap_idx_d;
      seq_done_q <= seq_done_d;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    smpl_window_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wrt_smpl),
      .wr_addr (wr_ptr_q),
      .wr_data (new_smpl[ch*WIDTH +: WIDTH]),
      .rd_en   (rd_en_c),
      .rd_addr (rd_addr_c),
      .rd_data (smpl_out[ch*WIDTH +: WIDTH])
    );
  end

  assign seq      = seq_q;
  assign tap_idx  = tap_idx_q;
  assign seq_done = seq_done_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_smpl_window_buf.sv
// Bench for smpl_window_buf: two geometries (8/5 and 12/9) share one stimulus
// stream and are compared every cycle against a window/history model.
module tb_smpl_window_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt_smpl;
  logic [31:0] new_smpl;
  logic [31:0] so0, so1;
  logic        seq0, seq1, done0, done1, ovr0, ovr1;
  logic [2:0]  tap0;
  logic [3:0]  tap1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  smpl_window_buf #(.WIDTH(16), .CHANNELS(2), .DEPTH(8), .WINDOW(5)) u_dut0 (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
    .smpl_out(so0), .seq(seq0), .tap_idx(tap0), .seq_done(done0), .ovr(ovr0)
  );

  smpl_window_buf #(.WIDTH(16), .CHANNELS(2), .DEPTH(12), .WINDOW(9)) u_dut1 (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
    .smpl_out(so1), .seq(seq1), .tap_idx(tap1), .seq_done(done1), .ovr(ovr1)
  );

  // Model state: full write history, and the window captured when tap 0 is read
  logic signed [15:0] hist0 [2][0:4095];
  logic signed [15:0] hist1 [2][0:4095];
  logic signed [15:0] win0  [2][0:15];
  logic signed [15:0] win1  [2][0:15];
  int     n_w[2], fill_m[2];
  bit     act_m[2], pend_m[2], ovr_m[2];
  longint l_m[2], bs_m[2];
  longint cyc_m = 0;
  bit     e_seq[2], e_done[2];
  int     e_tap[2];
  logic signed [15:0] e_d0[2], e_d1[2];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock of the model; l_m = cycle the tap-0 read happens, taps emerge one cycle later
  task automatic model_step(input int id);
    int  w;
    bit  busy;
    longint k;
    w = (id == 0) ? 5 : 9;
    if (rst) begin
      n_w[id] = 0; fill_m[id] = 0; act_m[id] = 0; pend_m[id] = 0; ovr_m[id] = 0;
      e_seq[id] = 0; e_tap[id] = 0; e_done[id] = 0; e_d0[id] = 0; e_d1[id] = 0;
      return;
    end
    if (act_m[id] && cyc_m == l_m[id]) begin
      for (int j = 0; j < w; j++) begin
        win0[id][j] = hist0[id][(n_w[id] - w + j) % 4096];
        win1[id][j] = hist1[id][(n_w[id] - w + j) % 4096];
      end
    end
    if (act_m[id] && cyc_m >= l_m[id] && cyc_m <= l_m[id] + w - 1) begin
      k = cyc_m - l_m[id];
      e_seq[id]  = 1;
      e_tap[id]  = int'(k);
      e_done[id] = (k == longint'(w - 1));
      e_d0[id]   = win0[id][k];
      e_d1[id]   = win1[id][k];
    end else begin
      e_seq[id] = 0; e_tap[id] = 0; e_done[id] = 0;
    end
    busy = act_m[id] && cyc_m >= bs_m[id] && cyc_m <= l_m[id] + w - 1;
    if (wrt_smpl) begin
      hist0[id][n_w[id] % 4096] = $signed(new_smpl[15:0]);
      hist1[id][n_w[id] % 4096] = $signed(new_smpl[31:16]);
      n_w[id]++;
      if (fill_m[id] < w) fill_m[id]++;
      if (busy) begin
        if (pend_m[id]) ovr_m[id] = 1;
        pend_m[id] = 1;
      end else if (fill_m[id] == w) begin
        act_m[id] = 1;
        l_m[id]   = cyc_m + 1;
        bs_m[id]  = cyc_m + 1;
      end
    end
    if (act_m[id] && cyc_m == l_m[id] + w - 1) begin
      if (pend_m[id]) begin
        pend_m[id] = 0;
        bs_m[id]   = l_m[id] + w;
        l_m[id]    = l_m[id] + w + 1;
      end else begin
        act_m[id] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    cyc_m++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("seq0",   longint'(seq0),  longint'(e_seq[0]));
      check("tap0",   longint'(tap0),  longint'(e_tap[0]));
      check("done0",  longint'(done0), longint'(e_done[0]));
      check("ovr0",   longint'(ovr0),  longint'(ovr_m[0]));
      check("d0ch0",  longint'($signed(so0[15:0])),  longint'(e_d0[0]));
      check("d0ch1",  longint'($signed(so0[31:16])), longint'(e_d1[0]));
      check("seq1",   longint'(seq1),  longint'(e_seq[1]));
      check("tap1",   longint'(tap1),  longint'(e_tap[1]));
      check("done1",  longint'(done1), longint'(e_done[1]));
      check("ovr1",   longint'(ovr1),  longint'(ovr_m[1]));
      check("d1ch0",  longint'($signed(so1[15:0])),  longint'(e_d0[1]));
      check("d1ch1",  longint'($signed(so1[31:16])), longint'(e_d1[1]));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic signed [15:0] a, input logic signed [15:0] b);
    wrt_smpl = 1'b1;
    new_smpl = {b, a};
    cyc();
    wrt_smpl = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wrt_smpl = 1'b0; new_smpl = '0;
    cyc(2);
    chk_en = 1'b1;
    check("rst_seq", longint'(seq0), 0);
    check("rst_ovr", longint'(ovr0), 0);
    check("rst_out", longint'(so0), 0);
    rst = 1'b0;
    cyc(3);

    // Priming: four writes give nothing, the fifth replays 1..5 / -1..-5
    for (int k = 1; k <= 4; k++) begin
      write(16'(k), 16'(-k));
      cyc(3);
    end
    check("unprimed_seq", longint'(seq0), 0);
    write(16'sd5, -16'sd5);
    cyc();
    check("t1_seq_tap0", longint'(seq0), 1);
    check("t1_tap0_idx", longint'(tap0), 0);
    check("t1_tap0_ch0", longint'($signed(so0[15:0])), 1);
    check("t1_tap0_ch1", longint'($signed(so0[31:16])), -1);
    cyc(4);
    check("t1_done", longint'(done0), 1);
    check("t1_tap4_idx", longint'(tap0), 4);
    check("t1_tap4_ch0", longint'($signed(so0[15:0])), 5);
    check("t1_tap4_ch1", longint'($signed(so0[31:16])), -5);
    cyc();
    check("t1_seq_end", longint'(seq0), 0);
    cyc(5);

    // Spaced writes wrapping the pointer of both geometries
    repeat (20) begin
      write(16'($urandom), 16'($urandom));
      cyc(9);
    end
    repeat (30) begin
      write(16'($urandom), 16'($urandom));
      cyc(11);
    end
    cyc(5);

    // Write during RUN at tap 2: one bubble then relaunch ending on the new sample
    write(16'sh0a0a, 16'sh0b0b);
    cyc(3);
    write(16'sh1234, -16'sh1234);
    cyc();
    cyc();
    check("t3_bubble", longint'(seq0), 0);
    cyc(5);
    check("t3_done", longint'(done0), 1);
    check("t3_last_ch0", longint'($signed(so0[15:0])), 16'sh1234);
    check("t3_last_ch1", longint'($signed(so0[31:16])), -16'sh1234);
    check("t3_ovr", longint'(ovr0), 0);
    cyc(12);

    // Two writes in one RUN: sticky overrun, single relaunch with newest data
    write(16'sh0101, 16'sh0202);
    cyc();
    write(16'sh0303, 16'sh0404);
    write(16'sh0505, 16'sh0606);
    check("t4_ovr", longint'(ovr0), 1);
    cyc(8);
    check("t4_done", longint'(done0), 1);
    check("t4_last_ch0", longint'($signed(so0[15:0])), 16'sh0505);
    cyc(15);
    check("t4_ovr_sticky", longint'(ovr0), 1);
    check("t4_idle", longint'(seq0), 0);

    // Asynchronous reset at tap 3, then re-priming from zero fill
    for (int k = 11; k <= 15; k++) begin
      write(16'(k), 16'(-k));
      if (k != 15) cyc(8);
    end
    cyc(4);
    check("t5_tap3", longint'(tap0), 3);
    #2 rst = 1'b1;
    #1;
    check("t5_async_seq", longint'(seq0), 0);
    check("t5_async_done", longint'(done0), 0);
    cyc();
    rst = 1'b0;
    cyc(2);
    check("t5_ovr_clr", longint'(ovr0), 0);
    for (int k = 21; k <= 24; k++) begin
      write(16'(k), 16'(-k));
      cyc(7);
    end
    check("t5_unprimed", longint'(seq0), 0);
    write(16'sd25, -16'sd25);
    cyc();
    check("t5_seq", longint'(seq0), 1);
    check("t5_tap0_ch0", longint'($signed(so0[15:0])), 21);
    cyc(12);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end
      wrt_smpl = ($urandom_range(0, 4) == 0);
      new_smpl = $urandom;
      cyc();
    end
    wrt_smpl = 1'b0;
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
